axis_tid_demux: RTL and testbench

- Packet-aware AXI4-Stream demultiplexer; sits directly downstream of the arbitrated mux (configured with UPDATE_TID=1).
- Routes each packet to one of M_COUNT outputs using the source-index bits the mux writes into the tid MSBs.
- Strips those bits from tid.
- Routes the first beat, locks the route for the whole packet, and drops packets with an out-of-range index.

---
 rtl/axis_pkg.sv | 17 +
 rtl/axis_skid_reg.sv | 58 +++++
 rtl/axis_tid_demux.sv | 159 +++++++++++++++
 tb/tb_axis_tid_demux.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the tid-routed AXI4-Stream demux: FSM state codes
// and the route-field width helper.
package axis_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Number of tid MSBs needed to address n outputs (ceil(log2(n))).
  function automatic int cl_m_count(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Output register plus skid (temp) register with a registered upstream ready,
// giving full throughput without a combinational ready path.
module axis_skid_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] out_data_p1;
  logic [DATA_W-1:0] tmp_data_p1;
  logic              out_vld_p1;
  logic              tmp_vld_p1;
  logic              rdy_p1;
  logic              rdy_early;

  // Temp is always empty whenever rdy_p1 is set, so two slots cover the
  // one-cycle lag of the registered ready.
  assign rdy_early = out_ready | (!tmp_vld_p1 & !out_vld_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_p1     <= 1'b0;
      out_vld_p1 <= 1'b0;
      tmp_vld_p1 <= 1'b0;
    end else begin
      rdy_p1 <= rdy_early;
      if (rdy_p1) begin
        if (out_ready || !out_vld_p1) out_vld_p1 <= in_valid;
        else                          tmp_vld_p1 <= in_valid;
      end else if (out_ready) begin
        out_vld_p1 <= tmp_vld_p1;
        tmp_vld_p1 <= 1'b0;
      end
    end
  end

  // stage p1: data registers follow the same steering as the valids
  always_ff @(posedge clk) begin
    if (rdy_p1) begin
      if (out_ready || !out_vld_p1) out_data_p1 <= in_data;
      else                          tmp_data_p1 <= in_data;
    end else if (out_ready) begin
      out_data_p1 <= tmp_data_p1;
    end
  end

  assign in_ready  = rdy_p1;
  assign out_data  = out_data_p1;
  assign out_valid = out_vld_p1;

endmodule

// File: rtl/axis_tid_demux.sv
// Packet-aware AXI4-Stream demux routing on the tid MSBs written by the upstream mux.
// Optional statistics counters are enabled with `define AXIS_TID_DEMUX_STATS_EN.
module axis_tid_demux
  import axis_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int S_ID_WIDTH  = 8 + $clog2(M_COUNT),
  parameter int M_ID_WIDTH  = S_ID_WIDTH - $clog2(M_COUNT),
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [S_ID_WIDTH-1:0]          s_axis_tid,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]             m_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_axis_tready,
  output logic [M_COUNT-1:0]             m_axis_tlast,
  output logic [M_COUNT*M_ID_WIDTH-1:0]  m_axis_tid,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser
`ifdef AXIS_TID_DEMUX_STATS_EN
  ,
  output logic [M_COUNT*32-1:0]          stat_pkt_count,
  output logic [31:0]                    stat_drop_count
`endif
);

  localparam int CL     = cl_m_count(M_COUNT);
  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + M_ID_WIDTH + USER_WIDTH;

  logic [1:0]            state;
  logic [CL-1:0]         idx;
  logic [CL-1:0]         sel_reg;
  logic [CL-1:0]         route_sel;
  logic                  idx_ok;
  logic                  drop;
  logic                  s_ready;
  logic                  s_hs;
  logic [M_COUNT-1:0]    ready_int;
  logic [M_COUNT-1:0]    beat_vld;
  logic [KEEP_WIDTH-1:0] keep_in;
  logic [USER_WIDTH-1:0] user_in;
  logic [BEAT_W-1:0]     in_beat;
  logic [BEAT_W-1:0]     out_beat [M_COUNT];

  assign idx    = s_axis_tid[S_ID_WIDTH-1 -: CL];
  assign idx_ok = (int'(idx) < M_COUNT);

  // Route decision: only the first beat's tid bits matter; later beats follow sel_reg.
  always_comb begin
    route_sel = sel_reg;
    drop      = 1'b0;
    s_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (idx_ok) begin
          route_sel = idx;
          s_ready   = ready_int[idx];
        end else begin
          drop    = 1'b1;
          s_ready = 1'b1;
        end
      end
      ST_ROUTE: s_ready = ready_int[sel_reg];
      ST_DROP: begin
        drop    = 1'b1;
        s_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_axis_tready = s_ready;
  assign s_hs          = s_axis_tvalid & s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_reg <= '0;
    end else if (s_hs) begin
      case (state)
        ST_IDLE: begin
          if (idx_ok) begin
            sel_reg <= idx;
            state   <= s_axis_tlast ? ST_IDLE : ST_ROUTE;
          end else begin
            state   <= s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end
        ST_ROUTE, ST_DROP: if (s_axis_tlast) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign keep_in = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
  assign user_in = USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}};
  assign in_beat = {s_axis_tdata, keep_in, s_axis_tlast,
                    s_axis_tid[M_ID_WIDTH-1:0], user_in};

  // stage p1: one skid register per output port
  for (genvar i = 0; i < M_COUNT; i++) begin : g_port
    assign beat_vld[i] = s_hs & !drop & (route_sel == CL'(i));

    axis_skid_reg #(
      .DATA_W(BEAT_W)
    ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_beat),
      .in_valid (beat_vld[i]),
      .in_ready (ready_int[i]),
      .out_data (out_beat[i]),
      .out_valid(m_axis_tvalid[i]),
      .out_ready(m_axis_tready[i])
    );

    assign {m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
            m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
            m_axis_tlast[i],
            m_axis_tid[i*M_ID_WIDTH +: M_ID_WIDTH],
            m_axis_tuser[i*USER_WIDTH +: USER_WIDTH]} = out_beat[i];
  end

`ifdef AXIS_TID_DEMUX_STATS_EN
  logic [31:0] drop_cnt;

  // A dropped packet is counted on its first beat, which is always taken in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  drop_cnt <= '0;
    else if (s_hs && state == ST_IDLE && !idx_ok) drop_cnt <= drop_cnt + 32'd1;
  end

  assign stat_drop_count = drop_cnt;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_stat
    logic [31:0] pkt_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pkt_cnt <= '0;
      else if (m_axis_tvalid[i] && m_axis_tready[i] && m_axis_tlast[i])
        pkt_cnt <= pkt_cnt + 32'd1;
    end

    assign stat_pkt_count[i*32 +: 32] = pkt_cnt;
  end
`endif

endmodule

// File: tb/tb_axis_tid_demux.sv
// Self-checking bench for axis_tid_demux: table-driven packets with a per-port
// scoreboard, plus hand sequences for back-pressure, drop and reset corners.
module tb_axis_tid_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tkeep = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [9:0]  s_tid = '0;
  logic        s_tuser = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_tready = 4'hF;
  logic [3:0]  m_tlast;
  logic [31:0] m_tid;
  logic [3:0]  m_tuser;

  logic        s3_tvalid = 1'b0;
  logic        s3_tready;
  logic [23:0] m3_tdata;
  logic [2:0]  m3_tkeep;
  logic [2:0]  m3_tvalid;
  logic [2:0]  m3_tready = 3'b111;
  logic [2:0]  m3_tlast;
  logic [23:0] m3_tid;
  logic [2:0]  m3_tuser;
`ifdef AXIS_TID_DEMUX_STATS_EN
  logic [127:0] stat_pkt;
  logic [31:0]  stat_drop;
  logic [95:0]  stat3_pkt;
  logic [31:0]  stat3_drop;
`endif

  int tests = 0;
  int fails = 0;
  logic [18:0] expq [4][$];

  always #5 clk = ~clk;

  axis_tid_demux #(.M_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tuser(m_tuser)
`ifdef AXIS_TID_DEMUX_STATS_EN
    , .stat_pkt_count(stat_pkt), .stat_drop_count(stat_drop)
`endif
  );

  axis_tid_demux #(.M_COUNT(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s3_tvalid),
    .s_axis_tready(s3_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m3_tdata), .m_axis_tkeep(m3_tkeep), .m_axis_tvalid(m3_tvalid),
    .m_axis_tready(m3_tready), .m_axis_tlast(m3_tlast), .m_axis_tid(m3_tid),
    .m_axis_tuser(m3_tuser)
`ifdef AXIS_TID_DEMUX_STATS_EN
    , .stat_pkt_count(stat3_pkt), .stat_drop_count(stat3_drop)
`endif
  );

  typedef struct {
    logic [1:0] rt;
    logic [7:0] d;
    logic       l;
    int         ep;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_beat(input logic [1:0] rt, input logic [7:0] d, input logic l);
    s_tdata = d;
    s_tid   = {rt, d ^ 8'hA5};
    s_tlast = l;
    s_tuser = d[0];
  endtask

  task automatic send(input logic [1:0] rt, input logic [7:0] d, input logic l,
                      input int ep, input int maxw, output logic acc, output int cyc);
    set_beat(rt, d, l);
    s_tvalid = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < maxw) begin
      @(negedge clk);
      acc = s_tready;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (acc && ep >= 0) expq[ep].push_back({d, 1'b1, l, d ^ 8'hA5, d[0]});
  endtask

  task automatic send_ok(input logic [1:0] rt, input logic [7:0] d, input logic l, input int ep);
    logic acc;
    int   cyc;
    send(rt, d, l, ep, 60, acc, cyc);
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic monitor();
    logic [18:0] act;
    logic [18:0] req;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          if (m_tvalid[i] && m_tready[i]) begin
            act = {m_tdata[i*8 +: 8], m_tkeep[i], m_tlast[i], m_tid[i*8 +: 8], m_tuser[i]};
            tests++;
            if (expq[i].size() == 0) begin
              fails++;
              $display("FAIL port%0d unexpected beat: got %h, expected none", i, act);
            end else begin
              req = expq[i].pop_front();
              if (act !== req) begin
                fails++;
                $display("FAIL port%0d beat: got %h, expected %h", i, act, req);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 4; i++) check(name, 32'(expq[i].size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [12];
    logic        acc;
    int          cyc;
    int          total;
    logic [3:0]  pat;

    tbl[0]  = '{2'd2, 8'h10, 1'b0, 2};
    tbl[1]  = '{2'd2, 8'h11, 1'b0, 2};
    tbl[2]  = '{2'd2, 8'h12, 1'b0, 2};
    tbl[3]  = '{2'd2, 8'h13, 1'b1, 2};
    tbl[4]  = '{2'd1, 8'h20, 1'b0, 1};
    tbl[5]  = '{2'd3, 8'h21, 1'b0, 1};
    tbl[6]  = '{2'd3, 8'h22, 1'b0, 1};
    tbl[7]  = '{2'd2, 8'h23, 1'b1, 1};
    tbl[8]  = '{2'd0, 8'h50, 1'b1, 0};
    tbl[9]  = '{2'd1, 8'h51, 1'b1, 1};
    tbl[10] = '{2'd2, 8'h52, 1'b1, 2};
    tbl[11] = '{2'd3, 8'h53, 1'b1, 3};

    fork
      monitor();
    join_none

    tick(3);
    check("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    check("rst_s_tready", 32'(s_tready), 32'h0);
    rst = 1'b0;
    tick(2);
    check("ready_after_rst", 32'(s_tready), 32'h1);

    // Packets routed on first beat, route locked mid-packet, back-to-back singles.
    total = 0;
    for (int k = 0; k < 12; k++) begin
      send(tbl[k].rt, tbl[k].d, tbl[k].l, tbl[k].ep, 60, acc, cyc);
      check("table_accept", 32'(acc), 32'd1);
      total += cyc;
    end
    s_tvalid = 1'b0;
    check("throughput_cycles", 32'(total), 32'd12);
    tick(6);
    check_drained("table_drain");

    // One-clock latency from handshake to m_axis_tvalid on an idle port.
    send_ok(2'd3, 8'h60, 1'b1, 3);
    s_tvalid = 1'b0;
    check("latency_valid", 32'(m_tvalid), 32'h8);
    check("latency_tid", 32'(m_tid[31:24]), 32'(8'h60 ^ 8'hA5));
    tick(3);

    // Back-pressure: port 1 parked, port 0 stalls input after two beats.
    m_tready = 4'b1101;
    send_ok(2'd1, 8'h30, 1'b0, 1);
    send_ok(2'd1, 8'h31, 1'b1, 1);
    m_tready = 4'b1100;
    send_ok(2'd0, 8'h40, 1'b0, 0);
    send_ok(2'd0, 8'h41, 1'b0, 0);
    send(2'd0, 8'h42, 1'b0, 0, 4, acc, cyc);
    check("stall_within_2", 32'(acc), 32'd0);
    m_tready[1] = 1'b1;
    tick(4);
    check("port1_drains", 32'(expq[1].size()), 32'd0);
    @(negedge clk);
    check("stall_hold", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    pat = 4'b1001;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          m_tready[0] = pat[k % 4];
          @(posedge clk);
          #1;
        end
        m_tready[0] = 1'b1;
      end
    join_none
    send_ok(2'd0, 8'h42, 1'b0, 0);
    send_ok(2'd0, 8'h43, 1'b0, 0);
    send_ok(2'd0, 8'h44, 1'b0, 0);
    send_ok(2'd0, 8'h45, 1'b1, 0);
    s_tvalid = 1'b0;
    tick(24);
    check_drained("toggle_drain");

    // M_COUNT=3: route index 3 is dropped without back-pressure.
    for (int b = 0; b < 5; b++) begin
      set_beat(2'd3, 8'h90 + 8'(b), (b == 4));
      s3_tvalid = 1'b1;
      @(negedge clk);
      check("drop_ready", 32'(s3_tready), 32'd1);
      check("drop_no_valid", 32'(m3_tvalid), 32'd0);
      @(posedge clk);
      #1;
    end
    set_beat(2'd0, 8'hA0, 1'b1);
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      acc = s3_tready;
      @(posedge clk);
      #1;
    end
    s3_tvalid = 1'b0;
    check("m3_accept", 32'(acc), 32'd1);
    check("m3_valid", 32'(m3_tvalid), 32'h1);
    check("m3_data", 32'(m3_tdata[7:0]), 32'hA0);
    check("m3_tid", 32'(m3_tid[7:0]), 32'(8'hA0 ^ 8'hA5));
    check("m3_last_user_keep", 32'({m3_tlast[0], m3_tuser[0], m3_tkeep}), 32'b10111);
`ifdef AXIS_TID_DEMUX_STATS_EN
    check("stat3_drop", stat3_drop, 32'd1);
    check("stat_pkt_port2", stat_pkt[64 +: 32], 32'd2);
`endif
    tick(2);

    // Reset in the middle of a routed packet.
    m_tready = 4'b1101;
    send_ok(2'd1, 8'h70, 1'b0, 1);
    send_ok(2'd1, 8'h71, 1'b0, 1);
    set_beat(2'd1, 8'h72, 1'b0);
    rst = 1'b1;
    s_tvalid = 1'b0;
    #1;
    check("midrst_valid", 32'(m_tvalid), 32'h0);
    check("midrst_ready", 32'(s_tready), 32'h0);
    for (int i = 0; i < 4; i++) expq[i].delete();
`ifdef AXIS_TID_DEMUX_STATS_EN
    check("stat_pkt_rst", 32'(stat_pkt != '0), 32'd0);
    check("stat_drop_rst", stat3_drop, 32'd0);
`endif
    tick(2);
    rst = 1'b0;
    m_tready = 4'hF;
    tick(2);
    send_ok(2'd2, 8'h80, 1'b1, 2);
    s_tvalid = 1'b0;
    check("post_rst_route", 32'(m_tvalid), 32'h4);
    tick(4);
    check_drained("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
